// File: rtl/alsu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alsu_pipe
// Description : Two-stage pipelined ALSU with generic operand width, valid
//               qualification, error strobe and a timed LED blink sequencer
//               for invalid operations.
// Revision    : 1.0 - initial release
// ============================================================================
module alsu_pipe #(
    parameter int WIDTH          = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter int FULL_ADDER     = 1,
    parameter int LED_W          = 16,
    parameter int BLINK_PERIOD   = 4,
    parameter int BLINK_PULSES   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 direction,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic                 err,
    output logic [LED_W-1:0]     leds,
    output logic                 blink_busy
);

    localparam int c_OUT_W = 2 * WIDTH;
    localparam bit c_PRI_B = (INPUT_PRIORITY == "B");
    localparam bit c_USE_CIN = (FULL_ADDER != 0);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_XOR = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_MUL = 3'b011;
    localparam logic [2:0] c_OP_SHF = 3'b100;
    localparam logic [2:0] c_OP_ROT = 3'b101;

    localparam int c_CNT_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam int c_PUL_W = $clog2(BLINK_PULSES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLINK_PERIOD - 1);
    localparam logic [c_PUL_W-1:0] c_PUL_DONE = c_PUL_W'(BLINK_PULSES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } blink_state_t;

    // stage-1 registers
    logic             r_v1;
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_b1;
    logic [2:0]       r_op1;
    logic             r_cin1;
    logic             r_ser1;
    logic             r_dir1;
    logic             r_red_a1;
    logic             r_red_b1;
    logic             r_byp_a1;
    logic             r_byp_b1;

    // stage-2 combinational results
    logic [c_OUT_W-1:0] w_result;
    logic               w_invalid;
    logic               w_trig;
    logic               w_red;
    logic [WIDTH-1:0]   w_red_src;
    logic               w_cin_eff;

    // blink sequencer
    blink_state_t       r_state;
    blink_state_t       w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_PUL_W-1:0] r_pulse;
    logic [c_PUL_W-1:0] w_pulse_nxt;
    logic [c_PUL_W-1:0] w_pulse_inc;

    // Capture every input, including the valid strobe, on each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_a1     <= '0;
            r_b1     <= '0;
            r_op1    <= '0;
            r_cin1   <= 1'b0;
            r_ser1   <= 1'b0;
            r_dir1   <= 1'b0;
            r_red_a1 <= 1'b0;
            r_red_b1 <= 1'b0;
            r_byp_a1 <= 1'b0;
            r_byp_b1 <= 1'b0;
        end else begin
            r_v1     <= in_valid;
            r_a1     <= A;
            r_b1     <= B;
            r_op1    <= op;
            r_cin1   <= cin;
            r_ser1   <= serial_in;
            r_dir1   <= direction;
            r_red_a1 <= red_op_A;
            r_red_b1 <= red_op_B;
            r_byp_a1 <= bypass_A;
            r_byp_b1 <= bypass_B;
        end
    end

    // The priority operand decides both the first bypass and which reduction flag counts.
    assign w_red     = c_PRI_B ? r_red_b1 : r_red_a1;
    assign w_red_src = c_PRI_B ? r_b1 : r_a1;
    assign w_cin_eff = c_USE_CIN ? r_cin1 : 1'b0;

    // Stage-2 datapath: bypass priority, opcode decode and invalid detection.
    always_comb begin
        w_result  = '0;
        w_invalid = 1'b0;
        if (c_PRI_B ? r_byp_b1 : r_byp_a1) begin
            w_result = {{WIDTH{1'b0}}, (c_PRI_B ? r_b1 : r_a1)};
        end else if (c_PRI_B ? r_byp_a1 : r_byp_b1) begin
            w_result = {{WIDTH{1'b0}}, (c_PRI_B ? r_a1 : r_b1)};
        end else begin
            case (r_op1)
                c_OP_AND: w_result = w_red ? {{(c_OUT_W-1){1'b0}}, &w_red_src}
                                           : {{WIDTH{1'b0}}, r_a1 & r_b1};
                c_OP_XOR: w_result = w_red ? {{(c_OUT_W-1){1'b0}}, ^w_red_src}
                                           : {{WIDTH{1'b0}}, r_a1 ^ r_b1};
                c_OP_ADD: w_result = {{WIDTH{1'b0}}, r_a1} + {{WIDTH{1'b0}}, r_b1}
                                   + {{(c_OUT_W-1){1'b0}}, w_cin_eff};
                c_OP_MUL: w_result = {{WIDTH{1'b0}}, r_a1} * {{WIDTH{1'b0}}, r_b1};
                c_OP_SHF: w_result = r_dir1 ? {out[c_OUT_W-2:0], r_ser1}
                                            : {r_ser1, out[c_OUT_W-1:1]};
                c_OP_ROT: w_result = r_dir1 ? {out[c_OUT_W-2:0], out[c_OUT_W-1]}
                                            : {out[0], out[c_OUT_W-1:1]};
                default:  w_invalid = 1'b1;
            endcase
            // Both reductions at once is meaningless for the arithmetic/shift ops.
            if (r_red_a1 && r_red_b1 && (r_op1 >= c_OP_ADD) && (r_op1 <= c_OP_ROT)) begin
                w_invalid = 1'b1;
            end
            if (w_invalid) begin
                w_result = '0;
            end
        end
    end

    assign w_trig = r_v1 && w_invalid;

    // Result register and single-cycle status strobes; out holds when no op is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= r_v1;
            err       <= w_trig;
            if (r_v1) begin
                out <= w_result;
            end
        end
    end

    // Sequencer state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pulse <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    assign w_pulse_inc = r_pulse + 1'b1;

    // Sequencer next state: a trigger always restarts at ON with cleared counters.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = r_pulse;
        if (w_trig) begin
            w_state_nxt = S_ON;
            w_cnt_nxt   = '0;
            w_pulse_nxt = '0;
        end else begin
            case (r_state)
                S_ON: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = S_OFF;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_OFF: begin
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nxt = '0;
                        if (w_pulse_inc == c_PUL_DONE) begin
                            w_state_nxt = S_IDLE;
                            w_pulse_nxt = '0;
                        end else begin
                            w_state_nxt = S_ON;
                            w_pulse_nxt = w_pulse_inc;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = '0;
                end
            endcase
        end
    end

    // LEDs are decoded straight from the state so reset blanks them immediately.
    assign leds       = (r_state == S_ON) ? {LED_W{1'b1}} : {LED_W{1'b0}};
    assign blink_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alsu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alsu_pipe
// Description : Directed self-checking bench for alsu_pipe. Three instances:
//               WIDTH=3 with priority "A", WIDTH=3 with priority "B" (both
//               with a 2-cycle / 2-pulse blink), and WIDTH=4 with defaults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alsu_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] A;
    logic [2:0] B;
    logic [3:0] A4;
    logic [3:0] B4;
    logic [2:0] op;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_op_A;
    logic       red_op_B;
    logic       bypass_A;
    logic       bypass_B;

    logic [5:0]  out_a;
    logic        ov_a;
    logic        err_a;
    logic [15:0] leds_a;
    logic        busy_a;
    logic [5:0]  out_b;
    logic        ov_b;
    logic        err_b;
    logic [15:0] leds_b;
    logic        busy_b;
    logic [7:0]  out_w;
    logic        ov_w;
    logic        err_w;
    logic [15:0] leds_w;
    logic        busy_w;

    int n_pass;
    int n_total;

    alsu_pipe #(.WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER(1), .LED_W(16),
                .BLINK_PERIOD(2), .BLINK_PULSES(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .op(op),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
        .bypass_B(bypass_B), .out(out_a), .out_valid(ov_a), .err(err_a),
        .leds(leds_a), .blink_busy(busy_a)
    );

    alsu_pipe #(.WIDTH(3), .INPUT_PRIORITY("B"), .FULL_ADDER(1), .LED_W(16),
                .BLINK_PERIOD(2), .BLINK_PULSES(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .op(op),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
        .bypass_B(bypass_B), .out(out_b), .out_valid(ov_b), .err(err_b),
        .leds(leds_b), .blink_busy(busy_b)
    );

    alsu_pipe #(.WIDTH(4), .INPUT_PRIORITY("A"), .FULL_ADDER(1), .LED_W(16),
                .BLINK_PERIOD(4), .BLINK_PULSES(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A4), .B(B4), .op(op),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
        .bypass_B(bypass_B), .out(out_w), .out_valid(ov_w), .err(err_w),
        .leds(leds_w), .blink_busy(busy_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected blink pattern for BLINK_PERIOD=2, BLINK_PULSES=2, sampled after
    // each edge starting with the edge that raises err.
    logic [15:0] exp_leds [10];
    logic        exp_busy [10];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [2:0] a,
                         input logic [2:0] b, input logic c, input logic si,
                         input logic dir, input logic ra, input logic rb,
                         input logic ba, input logic bb);
        in_valid  = v;
        op        = o;
        A         = a;
        B         = b;
        A4        = {1'b0, a};
        B4        = {1'b0, b};
        cin       = c;
        serial_in = si;
        direction = dir;
        red_op_A  = ra;
        red_op_B  = rb;
        bypass_A  = ba;
        bypass_B  = bb;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if ({out_a, ov_a, err_a, leds_a, busy_a} !== 25'd0)
            $display("FAIL reset_a: got %h expected 0", {out_a, ov_a, err_a, leds_a, busy_a});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        cyc();
        n_total++;
        if (ov_a !== 1'b0 || out_w !== 8'd0)
            $display("FAIL reset_idle: ov=%b out_w=%0d expected ov=0 out_w=0", ov_a, out_w);
        else n_pass++;
    endtask

    task automatic test_add_mul();
        drive(1'b1, 3'b010, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle();
        n_total++;
        if (ov_a !== 1'b0)
            $display("FAIL add_latency: out_valid=%b expected 0 after one edge", ov_a);
        else n_pass++;
        cyc();
        n_total++;
        if (out_a !== 6'd15 || ov_a !== 1'b1)
            $display("FAIL add: out=%0d ov=%b expected out=15 ov=1", out_a, ov_a);
        else n_pass++;
        cyc();
        n_total++;
        if (ov_a !== 1'b0 || out_a !== 6'd15)
            $display("FAIL add_strobe: ov=%b out=%0d expected ov=0 out=15", ov_a, out_a);
        else n_pass++;
        drive(1'b1, 3'b011, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle();
        cyc();
        n_total++;
        if (out_a !== 6'd49 || ov_a !== 1'b1)
            $display("FAIL mul: out=%0d ov=%b expected out=49 ov=1", out_a, ov_a);
        else n_pass++;
    endtask

    task automatic test_priority();
        drive(1'b1, 3'b010, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        idle();
        cyc();
        n_total++;
        if (out_a !== 6'd5 || out_b !== 6'd2)
            $display("FAIL bypass_pri: out_a=%0d out_b=%0d expected 5 and 2", out_a, out_b);
        else n_pass++;
        drive(1'b1, 3'b000, 3'd7, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        idle();
        cyc();
        n_total++;
        if (out_a !== 6'd1 || out_b !== 6'd2)
            $display("FAIL and_red_pri: out_a=%0d out_b=%0d expected 1 and 2", out_a, out_b);
        else n_pass++;
    endtask

    task automatic test_shift_rotate();
        logic [5:0] exp_sh [3];
        exp_sh[0] = 6'b000011;
        exp_sh[1] = 6'b000111;
        exp_sh[2] = 6'b001111;
        drive(1'b1, 3'b000, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 3'b100, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        n_total++;
        if (out_a !== 6'b000001)
            $display("FAIL preload: out=%b expected 000001", out_a);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i == 2)
                drive(1'b1, 3'b101, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
            n_total++;
            if (out_a !== exp_sh[i] || ov_a !== 1'b1)
                $display("FAIL shift_%0d: out=%b ov=%b expected %b ov=1", i, out_a, ov_a, exp_sh[i]);
            else n_pass++;
        end
        in_valid = 1'b0;
        cyc();
        n_total++;
        if (out_a !== 6'b100111 || ov_a !== 1'b1)
            $display("FAIL rotate_r: out=%b ov=%b expected 100111 ov=1", out_a, ov_a);
        else n_pass++;
        cyc();
        n_total++;
        if (out_a !== 6'b100111 || ov_a !== 1'b0)
            $display("FAIL hold: out=%b ov=%b expected 100111 ov=0", out_a, ov_a);
        else n_pass++;
    endtask

    task automatic test_invalid_blink();
        drive(1'b1, 3'b110, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle();
        cyc();
        n_total++;
        if (out_a !== 6'd0 || err_a !== 1'b1 || ov_a !== 1'b1)
            $display("FAIL invalid: out=%0d err=%b ov=%b expected 0 1 1", out_a, err_a, ov_a);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc();
            n_total++;
            if (leds_a !== exp_leds[k] || busy_a !== exp_busy[k] || (k > 0 && err_a !== 1'b0))
                $display("FAIL blink_%0d: leds=%h busy=%b err=%b expected leds=%h busy=%b",
                         k, leds_a, busy_a, err_a, exp_leds[k], exp_busy[k]);
            else n_pass++;
        end
    endtask

    task automatic test_blink_restart();
        drive(1'b1, 3'b110, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 3'b111, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle();
        cyc();
        n_total++;
        if (err_a !== 1'b1)
            $display("FAIL restart_err: err=%b expected 1", err_a);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc();
            n_total++;
            if (leds_a !== exp_leds[k] || busy_a !== exp_busy[k])
                $display("FAIL restart_%0d: leds=%h busy=%b expected leds=%h busy=%b",
                         k, leds_a, busy_a, exp_leds[k], exp_busy[k]);
            else n_pass++;
        end
    endtask

    task automatic test_double_reduction();
        drive(1'b1, 3'b000, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 3'b011, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        idle();
        n_total++;
        if (out_a !== 6'd5)
            $display("FAIL red_preload: out=%0d expected 5", out_a);
        else n_pass++;
        cyc();
        n_total++;
        if (out_a !== 6'd0 || err_a !== 1'b1 || ov_a !== 1'b1 || leds_a !== 16'hFFFF)
            $display("FAIL red_both_mul: out=%0d err=%b ov=%b leds=%h expected 0 1 1 FFFF",
                     out_a, err_a, ov_a, leds_a);
        else n_pass++;
        drive(1'b1, 3'b001, 3'b100, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        idle();
        cyc();
        n_total++;
        if (out_a !== 6'd1 || out_b !== 6'd1 || err_a !== 1'b0)
            $display("FAIL red_both_xor: out_a=%0d out_b=%0d err=%b expected 1 1 0",
                     out_a, out_b, err_a);
        else n_pass++;
    endtask

    task automatic test_w4_reset();
        drive(1'b1, 3'b011, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        A4 = 4'd15;
        B4 = 4'd15;
        cyc();
        idle();
        cyc();
        n_total++;
        if (out_w !== 8'd225 || ov_w !== 1'b1)
            $display("FAIL mul_w4: out=%0d ov=%b expected 225 1", out_w, ov_w);
        else n_pass++;
        drive(1'b1, 3'b110, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 3'b010, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle();
        cyc();
        n_total++;
        if (out_w !== 8'd7 || ov_w !== 1'b1 || leds_w !== 16'hFFFF || busy_w !== 1'b1)
            $display("FAIL pre_rst: out=%0d ov=%b leds=%h busy=%b expected 7 1 FFFF 1",
                     out_w, ov_w, leds_w, busy_w);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({out_w, ov_w, err_w, leds_w, busy_w} !== 27'd0 || leds_a !== 16'd0 || busy_a !== 1'b0)
            $display("FAIL async_rst: w=%h leds_a=%h busy_a=%b expected all 0",
                     {out_w, ov_w, err_w, leds_w, busy_w}, leds_a, busy_a);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 3'b010, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        A4 = 4'd5;
        B4 = 4'd6;
        cyc();
        idle();
        n_total++;
        if (ov_w !== 1'b0)
            $display("FAIL post_rst_lat: ov=%b expected 0", ov_w);
        else n_pass++;
        cyc();
        n_total++;
        if (out_w !== 8'd12 || ov_w !== 1'b1)
            $display("FAIL post_rst_add: out=%0d ov=%b expected 12 1", out_w, ov_w);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_leds = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF,
                     16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rst = 1'b1;
        idle();
        test_reset();
        test_add_mul();
        test_priority();
        test_shift_rotate();
        test_invalid_blink();
        test_blink_restart();
        test_double_reduction();
        test_w4_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alsu_pipe.md
Name: alsu_pipe

Overview:
Parametrised, pipelined successor to the team's 3-bit ALSU. Operand width is generic, operations are qualified by a valid strobe, and invalid operations raise an error flag and drive a timed LED blink sequencer instead of a single-cycle LED flip. It sits between the board switch/debounce logic and the 7-seg/LED drivers.

Parameters:
WIDTH, 3, operand width for A and B; the result width OUT_W is fixed at 2*WIDTH
INPUT_PRIORITY, "A", "A" or "B"; selects which bypass and which reduction flag takes precedence
FULL_ADDER, 1, 1 makes ADD compute A+B+cin; 0 makes it compute A+B
LED_W, 16, LED bus width
BLINK_PERIOD, 4, clk cycles per LED on-phase and per LED off-phase; must be >= 1
BLINK_PULSES, 2, number of on/off pulses per invalid-op event; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  qualifies all operand and control inputs this cycle
A  in  WIDTH  operand A
B  in  WIDTH  operand B
op  in  3  opcode: 000 AND, 001 XOR, 010 ADD, 011 MUL, 100 SHIFT, 101 ROTATE, 110/111 invalid
cin  in  1  carry in for ADD
serial_in  in  1  shift-in bit
direction  in  1  1 = left, 0 = right
red_op_A  in  1  reduction on A
red_op_B  in  1  reduction on B
bypass_A  in  1  pass A through
bypass_B  in  1  pass B through
out  out  OUT_W  result register
out_valid  out  1  one-cycle strobe when out was updated
err  out  1  one-cycle strobe on an invalid operation
leds  out  LED_W  blink indicator
blink_busy  out  1  high while the blink sequencer is active

Behaviour:
- Reset (asynchronous) clears all stage-1 registers, out, out_valid, err, leds, blink_busy, and both blink counters. The sequencer returns to IDLE.
- Stage 1: on every clk edge, all inputs including in_valid are registered (v1).
- Stage 2 executes only when v1=1. Result lands in out one edge after stage 1, so total latency is 2 cycles from in_valid to out_valid. When v1=0, out holds and out_valid and err are 0.
- Priority when INPUT_PRIORITY="A": bypass_A, then bypass_B, then the op decode. When "B", the bypasses swap order.
- AND/XOR: reduction applies when the priority operand's red_op flag is set (red_op_A for "A", red_op_B for "B"). A reduction produces 1 bit, zero-extended. Otherwise the op is bitwise on A and B, zero-extended.
- ADD: unsigned A+B(+cin), zero-extended to OUT_W; it never overflows.
- MUL: unsigned A*B, exactly OUT_W bits.
- SHIFT: shifts the current out register. direction=1 gives {out[OUT_W-2:0],serial_in}; direction=0 gives {serial_in,out[OUT_W-1:1]}.
- ROTATE: rotates the current out register. Left gives {out[OUT_W-2:0],out[OUT_W-1]}; right gives {out[0],out[OUT_W-1:1]}.
- Bypass output is zero-extended.
- Invalid is op in {110,111}, or red_op_A && red_op_B with op in 010..101, with no bypass active. On invalid: out<=0, out_valid=1, err=1 for that cycle, and the sequencer is triggered.
- Sequencer FSM, IDLE -> ON -> OFF -> (ON | IDLE):
  - Trigger: go to ON with leds all ones, cycle counter 0, pulse counter 0.
  - ON and OFF each last BLINK_PERIOD cycles. leds is all ones in ON and 0 in OFF.
  - At the end of OFF, the pulse counter increments. If it equals BLINK_PULSES, go to IDLE with leds=0; otherwise go to ON.
  - blink_busy = (state != IDLE).
  - A new trigger while busy restarts the sequence at ON with the counters cleared.
  - leds is 0 in IDLE.
- Valid ops during a blink execute normally and do not affect the sequencer.
- Reset mid-operation or mid-blink forces all outputs to 0 immediately, without waiting for a clock edge.

Test Plan:
1. WIDTH=3, FULL_ADDER=1: in_valid=1 for one cycle, op=010, A=7, B=7, cin=1 -> two edges later out=6'd15, out_valid pulses one cycle; next op=011, A=7, B=7 -> out=6'd49.
2. Priority: bypass_A=bypass_B=1, A=5, B=2 -> out=5 with "A", out=2 with "B"; op=000, red_op_A=1, A=3'b111 -> out=1 with "A"; with "B" the AND is bitwise on A and B.
3. Shift/rotate: preload out=6'b000001 via bypass A=1. Three valid cycles of op=100, direction=1, serial_in=1 -> 000011, 000111, 001111. Then op=101, direction=0 -> 100111. in_valid=0 with the same op -> out holds and out_valid stays 0.
4. Invalid: op=110 with BLINK_PERIOD=2, BLINK_PULSES=2 -> out=0, err pulse, out_valid pulse. Then leds=FFFF for 2 cycles, 0000 for 2, FFFF for 2, 0000 thereafter; blink_busy falls with the final OFF phase. A second op=111 during the first ON phase restarts the sequence from ON.
5. red_op_A=red_op_B=1 with op=011 -> invalid path as in 4; the same flags with op=001 under "A" -> out = ^A.
6. WIDTH=4: MUL A=15, B=15 -> out=8'd225. Assert rst mid-blink and mid-pipeline -> out, leds, err, out_valid, blink_busy all 0 before the next clk edge; the first valid input after release completes with 2-cycle latency.
